// File: rtl/dcache_pkg.sv
// Geometry, address field positions and FSM encodings for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int INDEX_W        = 4;
    localparam int TAG_W          = 24;
    localparam int OFFSET_W       = 4;
    localparam int WORD_SEL_W     = 2;
    localparam int NUM_SETS       = 1 << INDEX_W;
    localparam int WORDS_PER_LINE = 1 << WORD_SEL_W;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

    localparam int TAG_LSB   = INDEX_W + OFFSET_W;
    localparam int INDEX_LSB = OFFSET_W;
    localparam int WORD_LSB  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[TAG_LSB +: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_LSB +: INDEX_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[WORD_LSB +: WORD_SEL_W];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and line-buffer-side signals of the data cache in one bundle.
interface dcache_if;
    import dcache_pkg::*;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [WORD_W-1:0]     cpu_wdata;
    logic [WORD_W-1:0]     cpu_rdata;
    logic                  cpu_stall;
    logic                  mem_r;
    logic                  mem_w;
    logic [ADDR_W-1:0]     mem_addr;
    logic [LINE_W-1:0]     mem_wdata;
    logic [LINE_W-1:0]     mem_rdata;
    logic                  mem_ready;

    // The cache is the slave; the CPU plus line buffer environment is the master.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_stall, mem_r, mem_w, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_stall, mem_r, mem_w, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_store.sv
// Per-set valid/dirty/tag/data storage: combinational read, synchronous word and line writes.
module dcache_store
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_line,
    input  logic                  word_we,
    input  logic [INDEX_W-1:0]    word_index,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0]     word_data,
    input  logic                  line_we,
    input  logic [INDEX_W-1:0]    line_index,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [LINE_W-1:0]     line_data
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] valid_d;
    logic [NUM_SETS-1:0] dirty_q;
    logic [NUM_SETS-1:0] dirty_d;

    logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
    logic [LINE_W-1:0] data_mem [NUM_SETS];

    // A refill leaves the set clean; a store hit marks it dirty.
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set_state
        logic line_sel;
        logic word_sel_hit;
        assign line_sel     = line_we && (line_index == INDEX_W'(gi));
        assign word_sel_hit = word_we && (word_index == INDEX_W'(gi));
        assign valid_d[gi]  = line_sel ? 1'b1 : valid_q[gi];
        assign dirty_d[gi]  = line_sel ? 1'b0 : (word_sel_hit ? 1'b1 : dirty_q[gi]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[line_index]  <= line_tag;
            data_mem[line_index] <= line_data;
        end else if (word_we) begin
            data_mem[word_index][{word_sel, 5'b0} +: WORD_W] <= word_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller: hit logic, miss FSM, line-buffer muxing.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    dcache_if.slave  bus
);

    state_e state_q;
    state_e state_d;

    logic [INDEX_W-1:0]    req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_SEL_W-1:0] req_word;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic                  hit;
    logic                  word_we;
    logic                  line_we;
    logic                  unused_addr_bits;

    assign req_index        = addr_index(bus.cpu_addr);
    assign req_tag          = addr_tag(bus.cpu_addr);
    assign req_word         = addr_word(bus.cpu_addr);
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    dcache_store u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (req_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .word_we    (word_we),
        .word_index (req_index),
        .word_sel   (req_word),
        .word_data  (bus.cpu_wdata),
        .line_we    (line_we),
        .line_index (req_index),
        .line_tag   (req_tag),
        .line_data  (bus.mem_rdata)
    );

    assign hit           = rd_valid && (rd_tag == req_tag);
    assign bus.cpu_stall = bus.cpu_req && ((state_q != ST_IDLE) || !hit);
    assign bus.cpu_rdata = rd_line[{req_word, 5'b0} +: WORD_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The victim line and its address come straight from the store; the CPU holds
    // its address while stalled, so both stay put for the whole write-back.
    always_comb begin
        state_d       = state_q;
        word_we       = 1'b0;
        line_we       = 1'b0;
        bus.mem_r     = 1'b0;
        bus.mem_w     = 1'b0;
        bus.mem_addr  = {bus.cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        bus.mem_wdata = rd_line;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    if (hit) begin
                        word_we = bus.cpu_we;
                    end else if (rd_valid && rd_dirty) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_WB: begin
                bus.mem_w    = 1'b1;
                bus.mem_addr = {rd_tag, req_index, {OFFSET_W{1'b0}}};
                if (bus.mem_ready) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                bus.mem_r = 1'b1;
                if (bus.mem_ready) begin
                    line_we = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameters: none; geometry fixed by package constants (16 sets, 128-bit line, 24-bit tag).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req  input  1  CPU access request; held stable with cpu_we/addr/wdata while cpu_stall=1.
REQ-005 cpu_we  input  1  1=word store, 0=word load.
REQ-006 cpu_addr  input  32  byte address; tag=[31:8], index=[7:4], word=[3:2], [1:0] ignored.
REQ-007 cpu_wdata  input  32  store data.
REQ-008 cpu_rdata  output  32  load data, valid when cpu_req & ~cpu_we & ~cpu_stall.
REQ-009 cpu_stall  output  1  CPU must hold request and not advance.
REQ-010 mem_r  output  1  line refill request to line buffer.
REQ-011 mem_w  output  1  line write-back request to line buffer.
REQ-012 mem_addr  output  32  line address, bits [3:0]=0.
REQ-013 mem_wdata  output  128  victim line, word0 in [31:0].
REQ-014 mem_rdata  input  128  refill line, valid in the mem_ready cycle.
REQ-015 mem_ready  input  1  single-cycle completion pulse from line buffer.

Function
REQ-016 Direct-mapped, write-back, write-allocate; per set: valid, dirty, 24-bit tag, 4x32 data.
REQ-017 hit = valid[index] & (tag[index]==cpu_addr[31:8]); evaluated combinationally in IDLE.
REQ-018 FSM states IDLE, WB, REFILL; encodings from package.
REQ-019 IDLE, cpu_req & hit: zero-wait; load drives word[3:2] combinationally; store writes word, sets dirty, on same edge.
REQ-020 IDLE, cpu_req & miss & dirty victim -> WB; miss & clean/invalid -> REFILL.
REQ-021 cpu_stall = cpu_req & (state!=IDLE | ~hit); cpu_req=0 never stalls.
REQ-022 WB: mem_w=1, mem_addr={stored tag, index, 4'h0}, mem_wdata=victim line; on mem_ready -> REFILL.
REQ-023 REFILL: mem_r=1, mem_addr={cpu_addr[31:4], 4'h0}; on mem_ready write line, tag, valid=1, dirty=0 -> IDLE.
REQ-024 mem_r/mem_w SHALL be functions of state only; both 0 in IDLE; never both 1.
REQ-025 Request SHALL drop in the cycle after mem_ready unless the next state reissues (WB->REFILL back-to-back mem_r is legal and required).
REQ-026 mem_wdata/mem_addr stable for the entire WB state.
REQ-027 Retry after REFILL: access completes as a hit in the first IDLE cycle (one extra cycle beyond mem_ready).
REQ-028 mem_ready in IDLE ignored; cpu_addr change while stalled is a protocol violation (unchecked).

Reset
REQ-029 rst: state=IDLE, all valid=0, dirty=0; mem_r=mem_w=0; cpu_stall follows REQ-021 (miss).
REQ-030 rst mid-WB/REFILL aborts the transfer; dirty data is lost; data/tag arrays not reset.

Structure
REQ-031 Package dcache_pkg: INDEX_W=4, TAG_W=24, OFFSET_W=4, state encodings, address field positions.
REQ-032 One sub-module dcache_store: valid/dirty/tag/data arrays, combinational read, synchronous word and line write ports.
REQ-033 FSM, hit logic, and mem-side muxing in dcache_ctrl; mem side connects directly to the line buffer.

Verification
REQ-034 After reset load 0x0000_0104 -> stall; mem_r, mem_addr=0x0000_0100; ready with line {D,C,B,A} -> next IDLE cycle rdata=B, stall=0.
REQ-035 Store 0xDEADBEEF to 0x104 after REQ-034 -> no stall; load 0x104 -> 0xDEADBEEF same cycle.
REQ-036 Load 0x0000_1104 (same index, dirty) -> mem_w, mem_addr=0x100, mem_wdata word1=0xDEADBEEF; on ready mem_r with addr 0x1100 next cycle.
REQ-037 Line buffer model with 3-cycle-per-word delay -> mem_r/mem_w held until ready, dropped the next cycle, never both high.
REQ-038 rst asserted mid-REFILL -> mem_r=0 immediately; subsequent load of same address misses again.
REQ-039 cpu_req=0 for 10 cycles with random mem_ready pulses -> stall=0, no array change.
